// File: rtl/mem_bus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_bridge_pkg
// Shared definitions for the memory bus bridge slice: FSM state encoding,
// the CPU-phase constants that name each edge of the B_CLK/4 CPU cycle,
// default widths, and a phase-to-strobe decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_bus_bridge_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ACK_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Phase value *before* the edge of interest: the strobe for phase p
    // marks the B_CLK edge on which the phase advances from p to p+1.
    localparam logic [1:0] CPU_EDGE_PHASE     = 2'd1;
    localparam logic [1:0] CAPTURE_PHASE      = 2'd2;
    localparam logic [1:0] STALL_UPDATE_PHASE = 2'd0;

    // One-hot decode of the current phase into per-edge strobes.
    function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
        return 4'b0001 << ph;
    endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// mem_bus_bridge_if
// Bundles the CPU-side and memory-side signals of the bridge.
//   slave  : bridge view (CPU request + memory response in, CPU response +
//            memory request out)
//   master : environment view (CPU model and memory model), the opposite.
// Parameters: ADDR_W, DATA_W.
// ---------------------------------------------------------------------------
interface mem_bus_bridge_if
    import mem_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              CPU_REQ;
    logic              CPU_WE;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [DATA_W-1:0] CPU_WDATA;
    logic [DATA_W-1:0] CPU_RDATA;
    logic              CPU_STALL;
    logic              CPU_ERR;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              MEM_ACK;

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, MEM_RDATA, MEM_ACK,
        output CPU_RDATA, CPU_STALL, CPU_ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, MEM_RDATA, MEM_ACK,
        input  CPU_RDATA, CPU_STALL, CPU_ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
    );

endinterface

// File: rtl/mem_bus_bridge_phase.sv
// ---------------------------------------------------------------------------
// mem_bus_phase
// Free-running 2-bit phase counter that regenerates the B_CLK/4 CPU clock
// phase. edge_stb[p] is high while phase == p, i.e. it qualifies the next
// B_CLK edge as the p -> p+1 edge.
// Ports:
//   B_CLK    in   fast clock
//   RST      in   asynchronous active-high reset (phase -> 0)
//   phase    out  current phase 0..3
//   edge_stb out  one-hot per-edge strobes
// ---------------------------------------------------------------------------
module mem_bus_phase
    import mem_bus_bridge_pkg::*;
(
    input  logic       B_CLK,
    input  logic       RST,
    output logic [1:0] phase,
    output logic [3:0] edge_stb
);

    logic [1:0] phase_r;

    // Phase counter, wraps 3 -> 0.
    always_ff @(posedge B_CLK or posedge RST) begin
        if (RST) begin
            phase_r <= 2'd0;
        end else begin
            phase_r <= phase_r + 2'd1;
        end
    end

    assign phase    = phase_r;
    assign edge_stb = phase_onehot(phase_r);

endmodule

// File: rtl/mem_bus_bridge.sv
// ---------------------------------------------------------------------------
// mem_bus_bridge
// Memory-side responder for CPU accesses. The CPU runs at B_CLK/4; this block
// runs on B_CLK, captures one CPU request per CPU cycle, runs a req/ack
// handshake with memory and stalls the CPU when memory is slow.
// Ports:
//   B_CLK  in   fast clock (memory clock)
//   RST    in   asynchronous active-high reset
//   bus    slave modport of mem_bus_bridge_if (CPU_* and MEM_* signals)
// Optional feature: define MEM_BUS_BRIDGE_TIMEOUT_EN to abort an access after
// ACK_TIMEOUT B_CLK cycles in ISSUE (CPU_ERR set, read data all ones).
// Without it ISSUE waits for MEM_ACK indefinitely and CPU_ERR stays 0.
// ---------------------------------------------------------------------------
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT   // 3..255
`endif
)(
    input  logic B_CLK,
    input  logic RST,
    mem_bus_bridge_if.slave bus
);

    logic [1:0]        phase_s;
    logic [3:0]        ph_stb_s;
    logic              cap_stb_s;
    logic              cpu_edge_s;
    logic              stall_upd_s;
    logic              unused_stb_s;
    state_t            state_r;
    state_t            state_nxt_s;
    logic              capture_s;
    logic              ack_s;
    logic              tmo_s;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic              cpu_stall_r;
    logic              cpu_err_r;

    mem_bus_phase u_phase (
        .B_CLK    (B_CLK),
        .RST      (RST),
        .phase    (phase_s),
        .edge_stb (ph_stb_s)
    );

    assign cap_stb_s    = ph_stb_s[CAPTURE_PHASE];
    assign cpu_edge_s   = ph_stb_s[CPU_EDGE_PHASE];
    assign stall_upd_s  = ph_stb_s[STALL_UPDATE_PHASE];
    assign unused_stb_s = ph_stb_s[3];

    assign capture_s = (state_r == ST_ISSUE) ? 1'b0 :
                       ((state_r == ST_IDLE) && cap_stb_s && bus.CPU_REQ);
    assign ack_s     = (state_r == ST_ISSUE) && bus.MEM_ACK;

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(ACK_TIMEOUT);
    logic [7:0] tmo_cnt_r;

    // Cycles spent in ISSUE; cleared on capture (entry into ISSUE).
    always_ff @(posedge B_CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt_r <= 8'd0;
        end else if (capture_s) begin
            tmo_cnt_r <= 8'd0;
        end else if (state_r == ST_ISSUE) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Abort on the edge where the count reaches the limit, so MEM_REQ is
    // high for exactly ACK_TIMEOUT cycles.
    assign tmo_s = (state_r == ST_ISSUE) && !bus.MEM_ACK &&
                   ((tmo_cnt_r + 8'd1) == TMO_LIMIT);
`else
    assign tmo_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge B_CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; DONE is only left at an unstalled CPU edge so a
    // held request from a stalled CPU is never captured twice.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cap_stb_s && bus.CPU_REQ) state_nxt_s = ST_ISSUE;
                else                          state_nxt_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (bus.MEM_ACK || tmo_s) state_nxt_s = ST_DONE;
                else                      state_nxt_s = ST_ISSUE;
            end
            ST_DONE: begin
                if (cpu_edge_s && !cpu_stall_r) state_nxt_s = ST_IDLE;
                else                            state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request capture, completion/abort datapath and stall flag.
    always_ff @(posedge B_CLK or posedge RST) begin
        if (RST) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            cpu_rdata_r <= {DATA_W{1'b0}};
            cpu_stall_r <= 1'b0;
            cpu_err_r   <= 1'b0;
        end else begin
            if (capture_s) begin
                mem_we_r    <= bus.CPU_WE;
                mem_addr_r  <= bus.CPU_ADDR;
                mem_wdata_r <= bus.CPU_WDATA;
                mem_req_r   <= 1'b1;
                cpu_err_r   <= 1'b0;
            end else if (ack_s) begin
                mem_req_r <= 1'b0;
                if (!mem_we_r) cpu_rdata_r <= bus.MEM_RDATA;
            end else if (tmo_s) begin
                mem_req_r <= 1'b0;
                cpu_err_r <= 1'b1;
                if (!mem_we_r) cpu_rdata_r <= {DATA_W{1'b1}};
            end
            // Stall decision is made one edge ahead of the CPU edge.
            if (stall_upd_s) begin
                cpu_stall_r <= (state_r == ST_ISSUE) && !bus.MEM_ACK;
            end
        end
    end

    assign bus.MEM_REQ   = mem_req_r;
    assign bus.MEM_WE    = mem_we_r;
    assign bus.MEM_ADDR  = mem_addr_r;
    assign bus.MEM_WDATA = mem_wdata_r;
    assign bus.CPU_RDATA = cpu_rdata_r;
    assign bus.CPU_STALL = cpu_stall_r;
    assign bus.CPU_ERR   = cpu_err_r;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_bridge
// Directed bench for mem_bus_bridge: a CPU-side sequence in one initial block,
// a memory responder that acks a programmable number of cycles after MEM_REQ
// rises, and a queue of expected read data popped at each completing CPU edge.
// Timeout steps run only when MEM_BUS_BRIDGE_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_bus_bridge;

    logic B_CLK = 1'b0;
    logic RST   = 1'b1;

    mem_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_bridge dut (
        .B_CLK (B_CLK),
        .RST   (RST),
        .bus   (bus)
    );

    initial forever #5 B_CLK = ~B_CLK;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [1:0]  ph_m = 2'd0;
    int          ack_lat = 1;
    logic [31:0] rd_val = 32'h0;
    int          req_age = 0;
    int          last_len = 0;
    int          pulses = 0;
    int          rise_q[$];
    logic        req_prev = 1'b0;
    logic [31:0] exp_q[$];

    // Reference CPU phase: value before the next posedge.
    always @(posedge B_CLK or posedge RST) begin
        if (RST) ph_m <= 2'd0;
        else     ph_m <= ph_m + 2'd1;
    end

    always @(posedge B_CLK) cyc <= cyc + 1;

    // Memory responder: MEM_ACK is sampled by the DUT ack_lat edges after
    // the edge that raised MEM_REQ; ack_lat == 0 means never ack.
    always @(negedge B_CLK) begin
        if (bus.MEM_REQ) begin
            if (!req_prev) begin
                pulses++;
                rise_q.push_back(cyc);
            end
            req_age++;
            if (ack_lat != 0 && req_age == ack_lat) begin
                bus.MEM_ACK   = 1'b1;
                bus.MEM_RDATA = rd_val;
            end else begin
                bus.MEM_ACK   = 1'b0;
                bus.MEM_RDATA = ~rd_val;
            end
        end else begin
            if (req_prev) last_len = req_age;
            req_age       = 0;
            bus.MEM_ACK   = 1'b0;
            bus.MEM_RDATA = 32'h0;
        end
        req_prev = bus.MEM_REQ;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge B_CLK);
        #1;
    endtask

    task automatic wait_ph(input logic [1:0] p);
        for (int n = 0; n < 8 && ph_m != p; n++) step();
    endtask

    // One CPU access; returns the number of stalled CPU edges.
    task automatic cpu_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              input logic [31:0] rdv, input logic [31:0] exp_rd,
                              output int stalls);
        int          p0;
        logic        done;
        logic [31:0] e;
        wait_ph(2'd2);
        p0            = pulses;
        bus.CPU_REQ   = 1'b1;
        bus.CPU_WE    = we;
        bus.CPU_ADDR  = addr;
        bus.CPU_WDATA = wdata;
        ack_lat       = lat;
        rd_val        = rdv;
        if (!we) exp_q.push_back(exp_rd);
        step();
        chk("mem_req_up", {63'd0, bus.MEM_REQ}, 64'd1);
        chk("mem_addr", {32'd0, bus.MEM_ADDR}, {32'd0, addr});
        chk("mem_we", {63'd0, bus.MEM_WE}, {63'd0, we});
        if (we) chk("mem_wdata", {32'd0, bus.MEM_WDATA}, {32'd0, wdata});
        stalls = 0;
        done   = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            step();
            if (ph_m == 2'd1) begin
                if (bus.CPU_STALL) stalls++;
                else               done = 1'b1;
            end
        end
        chk("access_done", {63'd0, done}, 64'd1);
        if (!we) begin
            e = exp_q.pop_front();
            chk("cpu_rdata", {32'd0, bus.CPU_RDATA}, {32'd0, e});
        end
        step();
        bus.CPU_REQ = 1'b0;
        chk("single_pulse", 64'(pulses - p0), 64'd1);
    endtask

    initial begin
        int st;
        int p0;
        logic seen;
        bus.CPU_REQ   = 1'b0;
        bus.CPU_WE    = 1'b0;
        bus.CPU_ADDR  = 32'h0;
        bus.CPU_WDATA = 32'h0;

        // Reset state.
        step(); step(); step();
        chk("rst_mem_req",   {63'd0, bus.MEM_REQ},   64'd0);
        chk("rst_mem_we",    {63'd0, bus.MEM_WE},    64'd0);
        chk("rst_mem_addr",  {32'd0, bus.MEM_ADDR},  64'd0);
        chk("rst_mem_wdata", {32'd0, bus.MEM_WDATA}, 64'd0);
        chk("rst_cpu_rdata", {32'd0, bus.CPU_RDATA}, 64'd0);
        chk("rst_cpu_stall", {63'd0, bus.CPU_STALL}, 64'd0);
        chk("rst_cpu_err",   {63'd0, bus.CPU_ERR},   64'd0);
        chk("rst_phase",     {62'd0, dut.phase_s},   64'd0);
        RST = 1'b0;

        // Zero-wait read.
        cpu_access(1'b0, 32'h40, 32'h0, 1, 32'h12345678, 32'h12345678, st);
        chk("zw_stalls", 64'(st), 64'd0);
        chk("zw_req_len", 64'(last_len), 64'd1);

        // Write, ack after 2 cycles: read data register untouched.
        cpu_access(1'b1, 32'h80, 32'hA5A5A5A5, 2, 32'hDEAD0000, 32'h0, st);
        chk("wr_stalls", 64'(st), 64'd0);
        chk("wr_rdata_kept", {32'd0, bus.CPU_RDATA}, 64'h12345678);

        // Slow read: one stalled CPU edge, one MEM_REQ pulse.
        cpu_access(1'b0, 32'hC0, 32'h0, 6, 32'hCAFEF00D, 32'hCAFEF00D, st);
        chk("slow_stalls", 64'(st), 64'd1);
        chk("slow_req_len", 64'(last_len), 64'd6);

        // Idle CPU cycle: no memory activity.
        p0 = pulses;
        for (int i = 0; i < 8; i++) step();
        chk("idle_no_req", 64'(pulses - p0), 64'd0);

        // Back-to-back reads spaced one CPU cycle apart.
        for (int k = 0; k < 3; k++) begin
            cpu_access(1'b0, 32'(4 * k), 32'h0, 1, 32'h10000000 + 32'(k),
                       32'h10000000 + 32'(k), st);
            chk("b2b_stalls", 64'(st), 64'd0);
        end
        chk("b2b_gap1", 64'(rise_q[rise_q.size()-2] - rise_q[rise_q.size()-3]), 64'd4);
        chk("b2b_gap2", 64'(rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2]), 64'd4);

        // Reset in the middle of a stalled access.
        wait_ph(2'd2);
        bus.CPU_REQ  = 1'b1;
        bus.CPU_WE   = 1'b0;
        bus.CPU_ADDR = 32'h100;
        ack_lat      = 0;
        step(); step(); step();
        chk("pre_rst_stall", {63'd0, bus.CPU_STALL}, 64'd1);
        RST = 1'b1;
        #1;
        chk("mid_rst_req",   {63'd0, bus.MEM_REQ},   64'd0);
        chk("mid_rst_stall", {63'd0, bus.CPU_STALL}, 64'd0);
        chk("mid_rst_phase", {62'd0, dut.phase_s},   64'd0);
        step();
        ack_lat = 1;
        rd_val  = 32'h0BADCAFE;
        RST     = 1'b0;
        seen    = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            step();
            seen = bus.MEM_REQ;
        end
        chk("post_rst_capture", {63'd0, seen}, 64'd1);
        chk("post_rst_phase", {62'd0, ph_m}, 64'd3);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            seen = (ph_m == 2'd1) && !bus.CPU_STALL;
        end
        chk("post_rst_rdata", {32'd0, bus.CPU_RDATA}, 64'h0BADCAFE);
        step();
        bus.CPU_REQ = 1'b0;

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
        // Timeout: never ack.
        cpu_access(1'b0, 32'h200, 32'h0, 0, 32'h0, 32'hFFFFFFFF, st);
        chk("tmo_err", {63'd0, bus.CPU_ERR}, 64'd1);
        chk("tmo_req_len", 64'(last_len), 64'd15);
        cpu_access(1'b0, 32'h204, 32'h0, 1, 32'h55AA55AA, 32'h55AA55AA, st);
        chk("tmo_err_cleared", {63'd0, bus.CPU_ERR}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Memory-side responder for CPU accesses in the two-clock scheme, where the CPU runs on B_CLK/4 and memory runs on B_CLK. The block runs entirely on B_CLK and regenerates the CPU clock phase internally. It captures each CPU request once per CPU cycle, runs a req/ack handshake with memory, and returns read data before the next CPU rising edge. When memory is too slow, it stalls the CPU.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ACK_TIMEOUT, 15, B_CLK cycles in ISSUE before abort (only with timeout compiled in), range 3..255

- B_CLK  in  1  fast clock, same net as the memory clock
- RST  in  1  reset, asynchronous, active-high
- CPU_REQ  in  1  CPU access request, held for a full CPU cycle
- CPU_WE  in  1  1 = write, 0 = read
- CPU_ADDR  in  ADDR_W  access address
- CPU_WDATA  in  DATA_W  write data
- CPU_RDATA  out  DATA_W  read data, held until the next read completes
- CPU_STALL  out  1  CPU must hold its state at the next CPU edge
- CPU_ERR  out  1  last access timed out
- MEM_REQ  out  1  memory request
- MEM_WE, MEM_ADDR, MEM_WDATA  out  1/ADDR_W/DATA_W  registered copies of the captured request
- MEM_RDATA  in  DATA_W  memory read data, valid together with MEM_ACK
- MEM_ACK  in  1  memory completion; ignored while MEM_REQ=0

## Operation
- 2-bit phase counter: reset to 0, +1 every B_CLK, wraps 3→0. The "CPU edge" is the B_CLK edge at which phase goes 1→2; this matches the divider's output rising edge.
- FSM states: IDLE, ISSUE, DONE. Reset state is IDLE.
- IDLE→ISSUE: at the edge where phase=2, if CPU_REQ=1. On this edge, MEM_WE/ADDR/WDATA are loaded from the CPU inputs, MEM_REQ←1, and CPU_ERR←0. CPU_REQ is sampled at no other phase.
- ISSUE→DONE: at the first edge with MEM_ACK=1. On this edge, MEM_REQ←0, and if MEM_WE=0 then CPU_RDATA←MEM_RDATA. Writes leave CPU_RDATA unchanged.
- DONE→IDLE: at a CPU edge where CPU_STALL=0. Otherwise DONE holds.
- CPU_STALL: updated only at the edge where phase goes 0→1, to (state==ISSUE && !MEM_ACK). At all other edges it holds.
- A stalled CPU keeps its request asserted. Because the FSM stays out of IDLE until a non-stalled CPU edge, the held request is never re-captured.
- CPU_REQ=0 at the phase-2 edge: no memory activity for that CPU cycle.
- MEM_ACK while in IDLE or DONE: ignored.
- Reset asserted mid-access: all state clears immediately and MEM_REQ drops. Memory must treat a dropped MEM_REQ as an abort.
- Reset values: MEM_REQ 0, MEM_WE 0, MEM_ADDR 0, MEM_WDATA 0, CPU_RDATA 0, CPU_STALL 0, CPU_ERR 0, phase 0.

## Timing
- Capture occurs at the phase 2→3 edge (E0), and MEM_REQ is high from E0.
- MEM_ACK sampled at E0+1 or E0+2: no stall. Read data is stable at least one B_CLK before the CPU edge at E0+3.
- MEM_ACK sampled at E0+3 or later: CPU_STALL=1 for every CPU edge until a 0→1 phase edge finds the access complete.
- Stall cost: each stalled CPU cycle is 4 B_CLK.
- Throughput: at most one access per CPU cycle.

## Configuration
- Macro: MEM_BUS_BRIDGE_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entry to ISSUE and increments each cycle in ISSUE.
  - When the counter reaches ACK_TIMEOUT with MEM_ACK=0: MEM_REQ←0, state←DONE, CPU_ERR←1, and, for reads, CPU_RDATA←all ones.
- Without the macro: no counter, ISSUE waits indefinitely, and CPU_ERR is tied to 0.

## Structure
- Shared package contents: FSM state encoding (IDLE=0, ISSUE=1, DONE=2), phase constants (CPU_EDGE_PHASE=1, CAPTURE_PHASE=2, STALL_UPDATE_PHASE=0), and default widths.
- Sub-module: mem_bus_phase, the 2-bit phase counter. It outputs a one-hot strobe for each phase edge and is reset by RST.

## Test plan
- Zero-wait read: memory acks 1 cycle after MEM_REQ with MEM_RDATA=0x12345678, request CPU_ADDR=0x40 → MEM_ADDR=0x40, CPU_RDATA=0x12345678 before the next CPU edge, CPU_STALL stays 0.
- Write: CPU_WE=1, CPU_WDATA=0xA5A5A5A5, ack after 2 cycles → MEM_WE=1 and MEM_WDATA=0xA5A5A5A5 while MEM_REQ=1, CPU_RDATA unchanged, no stall.
- Slow read: ack 6 cycles after MEM_REQ → exactly one CPU edge with CPU_STALL=1, a single MEM_REQ pulse, and the held request is not re-issued.
- Back-to-back reads to 0x0, 0x4, 0x8 with 1-cycle ack → three MEM_REQ pulses spaced 4 B_CLK apart, each CPU_RDATA correct in order.
- Reset mid-access: assert RST during ISSUE → MEM_REQ, CPU_STALL and phase are 0 immediately; the first post-reset capture occurs at phase 2.
- Timeout (macro defined, ACK_TIMEOUT=15): never ack → MEM_REQ drops after 15 cycles, CPU_ERR=1, CPU_RDATA=0xFFFFFFFF, the next access clears CPU_ERR.
